// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN datapath blocks.
package snn_pkg;

   localparam int NUM_PIXELS = 784;
   localparam int BYTE_W     = 8;
   localparam int NUM_BYTES  = NUM_PIXELS / BYTE_W;
   localparam int NUM_HIDDEN = 32;
   localparam int NUM_OUT    = 10;
   localparam int PIX_ADDR_W = 10;
   localparam int BYTE_ADDR_W = $clog2(NUM_BYTES);

   typedef enum logic [1:0] {
      LOAD,
      START,
      RUN
   } loader_state_t;

endpackage

// File: rtl/ram_input_unit.sv
// Input image store: one byte per entry, one write port and one registered read port.
// A read of an address being written in the same cycle returns the old contents.
module ram_input_unit
   import snn_pkg::*;
(
   input  logic                   clk,
   input  logic                   we,
   input  logic [BYTE_ADDR_W-1:0] waddr,
   input  logic [BYTE_W-1:0]      data,
   input  logic [BYTE_ADDR_W-1:0] raddr,
   output logic [BYTE_W-1:0]      q
);

   logic [BYTE_W-1:0] r_mem [NUM_BYTES];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= data;
      end
      q <= r_mem[raddr];
   end

endmodule

// File: rtl/snn_input_loader.sv
// Collects a packed binary image from the UART, starts the SNN core, serves pixels
// to it, and hands the classified digit back toward the UART transmitter.
module snn_input_loader
   import snn_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [BYTE_W-1:0]     rx_data,
   input  logic                  rx_rdy,
   input  logic [PIX_ADDR_W-1:0] addr_input_unit,
   input  logic                  core_done,
   input  logic [3:0]            core_digit,
   output logic                  start,
   output logic                  q_input,
   output logic [3:0]            result,
   output logic                  result_vld,
   output logic                  busy,
   output logic                  rx_ovr
);

   loader_state_t r_state;
   loader_state_t w_nextState;

   logic [BYTE_ADDR_W-1:0] r_byteCnt;
   logic [2:0]             r_bitSel;
   logic                   r_addrValid;

   logic                   w_ramWe;
   logic                   w_lastByte;
   logic                   w_addrValid;
   logic [BYTE_ADDR_W-1:0] w_ramRaddr;
   logic [BYTE_W-1:0]      w_ramQ;

   // Out-of-image addresses are steered to entry 0 and masked on the output side
   assign w_addrValid = (addr_input_unit < PIX_ADDR_W'(NUM_PIXELS));
   assign w_ramRaddr  = w_addrValid ? addr_input_unit[PIX_ADDR_W-1:3] : '0;
   assign w_ramWe     = (r_state == LOAD) && rx_rdy;
   assign w_lastByte  = (r_byteCnt == BYTE_ADDR_W'(NUM_BYTES - 1));

   ram_input_unit u_ram (
      .clk   (clk),
      .we    (w_ramWe),
      .waddr (r_byteCnt),
      .data  (rx_data),
      .raddr (w_ramRaddr),
      .q     (w_ramQ)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= LOAD;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         LOAD:    if (rx_rdy && w_lastByte) w_nextState = START;
         START:   w_nextState = RUN;
         RUN:     if (core_done) w_nextState = LOAD;
         default: w_nextState = LOAD;
      endcase
   end

   always_comb begin
      start = 1'b0;
      busy  = 1'b0;
      case (r_state)
         START: begin
            start = 1'b1;
            busy  = 1'b1;
         end
         RUN:     busy = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_byteCnt   <= '0;
         result      <= '0;
         result_vld  <= 1'b0;
         rx_ovr      <= 1'b0;
         r_bitSel    <= '0;
         r_addrValid <= 1'b0;
      end else begin
         result_vld  <= 1'b0;
         rx_ovr      <= rx_rdy && (r_state != LOAD);
         r_bitSel    <= addr_input_unit[2:0];
         r_addrValid <= w_addrValid;
         if (w_ramWe) begin
            r_byteCnt <= w_lastByte ? '0 : r_byteCnt + 1'b1;
         end
         if ((r_state == RUN) && core_done) begin
            result     <= core_digit;
            result_vld <= 1'b1;
         end
      end
   end

   // Bit select lines up with the registered RAM word, so q_input lags the address by one cycle
   assign q_input = r_addrValid & w_ramQ[r_bitSel];

endmodule

// File: tb/tb_snn_input_loader.sv
// Directed self-checking bench for snn_input_loader: load, packing, overrun,
// completion, mid-load reset and coincident-event cases.
module tb_snn_input_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_rdy;
   logic [9:0] addr_input_unit;
   logic       core_done;
   logic [3:0] core_digit;
   logic       start;
   logic       q_input;
   logic [3:0] result;
   logic       result_vld;
   logic       busy;
   logic       rx_ovr;

   int         assertCount = 0;
   int         failCount   = 0;
   logic [7:0] image [98];

   always #5 clk = ~clk;

   snn_input_loader dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rx_data         (rx_data),
      .rx_rdy          (rx_rdy),
      .addr_input_unit (addr_input_unit),
      .core_done       (core_done),
      .core_digit      (core_digit),
      .start           (start),
      .q_input         (q_input),
      .result          (result),
      .result_vld      (result_vld),
      .busy            (busy),
      .rx_ovr          (rx_ovr)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs, then leaves the bench 1 time unit past the edge
   task automatic applyStimulus(input logic rdy, input logic [7:0] data, input logic done,
                                input logic [3:0] digit, input logic [9:0] addr);
      rx_rdy          = rdy;
      rx_data         = data;
      core_done       = done;
      core_digit      = digit;
      addr_input_unit = addr;
      @(posedge clk);
      #1;
      rx_rdy    = 1'b0;
      core_done = 1'b0;
   endtask

   task automatic sendImage(input int n, output int earlyStarts);
      earlyStarts = 0;
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b1, image[k], 1'b0, 4'd0, 10'd0);
         if ((k < 97) && (start !== 1'b0)) earlyStarts++;
      end
   endtask

   function automatic logic modelPixel(input int a);
      logic [7:0] b;
      if (a >= 784) return 1'b0;
      b = image[a >> 3];
      return b[a & 7];
   endfunction

   task automatic scanAll(output int mismatches);
      mismatches = 0;
      for (int a = 0; a < 1024; a++) begin
         applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 10'(a));
         if (q_input !== modelPixel(a)) mismatches++;
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_start"}, 32'(start), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_result"}, 32'(result), 32'd0);
      checkOutput({tag, "_result_vld"}, 32'(result_vld), 32'd0);
      checkOutput({tag, "_rx_ovr"}, 32'(rx_ovr), 32'd0);
      checkOutput({tag, "_q_input"}, 32'(q_input), 32'd0);
   endtask

   initial begin
      int early;
      int bad;

      rst_n           = 1'b0;
      rx_data         = 8'h00;
      rx_rdy          = 1'b0;
      addr_input_unit = 10'd0;
      core_done       = 1'b0;
      core_digit      = 4'd0;
      applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 10'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 10'd0);
      checkResetState("reset");
      rst_n = 1'b1;

      // Load an all-0xA5 image
      for (int k = 0; k < 98; k++) image[k] = 8'hA5;
      sendImage(98, early);
      checkOutput("load_no_early_start", 32'(early), 32'd0);
      checkOutput("load_start", 32'(start), 32'd1);
      checkOutput("load_busy", 32'(busy), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 10'd0);
      checkOutput("load_start_single", 32'(start), 32'd0);
      checkOutput("load_busy_run", 32'(busy), 32'd1);
      checkOutput("read_addr0", 32'(q_input), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 10'd1);
      checkOutput("read_addr1", 32'(q_input), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 10'd2);
      checkOutput("read_addr2", 32'(q_input), 32'd1);

      // Overrun while running: bytes dropped, image intact
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 8'hFF, 1'b0, 4'd0, 10'd0);
         checkOutput("overrun_rx_ovr", 32'(rx_ovr), 32'd1);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 10'd0);
      checkOutput("overrun_clear", 32'(rx_ovr), 32'd0);
      checkOutput("overrun_busy", 32'(busy), 32'd1);
      scanAll(bad);
      checkOutput("overrun_readback", 32'(bad), 32'd0);

      // Completion
      applyStimulus(1'b0, 8'h00, 1'b1, 4'd7, 10'd0);
      checkOutput("done_result", 32'(result), 32'd7);
      checkOutput("done_vld", 32'(result_vld), 32'd1);
      checkOutput("done_busy", 32'(busy), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 10'd0);
      checkOutput("done_vld_pulse", 32'(result_vld), 32'd0);
      checkOutput("done_result_hold", 32'(result), 32'd7);

      // Bit packing: only pixel 783 set
      for (int k = 0; k < 98; k++) image[k] = 8'h00;
      image[97] = 8'h80;
      sendImage(98, early);
      checkOutput("pack_no_early_start", 32'(early), 32'd0);
      checkOutput("pack_start", 32'(start), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 10'd783);
      checkOutput("pack_addr783", 32'(q_input), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 10'd782);
      checkOutput("pack_addr782", 32'(q_input), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 10'd784);
      checkOutput("pack_addr784", 32'(q_input), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 10'd1023);
      checkOutput("pack_addr1023", 32'(q_input), 32'd0);
      scanAll(bad);
      checkOutput("pack_scan", 32'(bad), 32'd0);

      // rx_rdy coincident with core_done
      applyStimulus(1'b1, 8'h55, 1'b1, 4'd3, 10'd0);
      checkOutput("coinc_rx_ovr", 32'(rx_ovr), 32'd1);
      checkOutput("coinc_vld", 32'(result_vld), 32'd1);
      checkOutput("coinc_result", 32'(result), 32'd3);
      checkOutput("coinc_busy", 32'(busy), 32'd0);

      // core_done in LOAD is ignored
      applyStimulus(1'b0, 8'h00, 1'b1, 4'd9, 10'd0);
      checkOutput("load_done_result", 32'(result), 32'd3);
      checkOutput("load_done_vld", 32'(result_vld), 32'd0);

      // Fresh image after the coincident case starts from byte 0
      for (int k = 0; k < 98; k++) image[k] = 8'(k * 7 + 3);
      sendImage(98, early);
      checkOutput("reload_no_early_start", 32'(early), 32'd0);
      checkOutput("reload_start", 32'(start), 32'd1);
      checkOutput("reload_no_ovr", 32'(rx_ovr), 32'd0);
      scanAll(bad);
      checkOutput("reload_scan", 32'(bad), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1, 4'd2, 10'd0);
      checkOutput("reload_result", 32'(result), 32'd2);

      // Reset mid-load abandons the partial image
      for (int k = 0; k < 98; k++) image[k] = 8'h11;
      sendImage(50, early);
      checkOutput("partial_no_start", 32'(early), 32'd0);
      checkOutput("partial_start_low", 32'(start), 32'd0);
      rst_n = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 10'd5);
      checkResetState("midreset");
      rst_n = 1'b1;
      for (int k = 0; k < 98; k++) image[k] = 8'(8'hC3 ^ k);
      sendImage(98, early);
      checkOutput("postreset_no_early_start", 32'(early), 32'd0);
      checkOutput("postreset_start", 32'(start), 32'd1);
      scanAll(bad);
      checkOutput("postreset_scan", 32'(bad), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1, 4'd5, 10'd0);
      checkOutput("postreset_result", 32'(result), 32'd5);
      checkOutput("postreset_vld", 32'(result_vld), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
